// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the leaky integrate-and-fire neuron sequencer:
// default parameter values and the sequencer state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package neuron_pkg;

    localparam int N_IN_DEF       = 8;    // number of synaptic inputs
    localparam int W_DEF          = 8;    // weight and potential width
    localparam int THRESH_DEF     = 128;  // firing threshold
    localparam int LEAK_SHIFT_DEF = 2;    // leak = v >> LEAK_SHIFT per tick
    localparam int REFRAC_DEF     = 2;    // refractory length in ticks

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAK  = 3'd1,
        ACCUM = 3'd2,
        FIRE  = 3'd3,
        REFR  = 3'd4
    } state_t;

endpackage

// File: rtl/leak_shift.sv
// -----------------------------------------------------------------------------
// leak_shift
// Combinational membrane leak: v_leaked = v - (v >> LEAK_SHIFT).
// Shift-and-subtract only, so the result never exceeds v and never wraps.
// Ports:
//   v         in  W  current membrane potential
//   v_leaked  out W  potential after one timestep of leak
// -----------------------------------------------------------------------------
module leak_shift #(
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 2
) (
    input  logic [W-1:0] v,
    output logic [W-1:0] v_leaked
);

    assign v_leaked = v - (v >> LEAK_SHIFT);

endmodule

// File: rtl/neuron_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_sequencer
// Time-multiplexed leaky integrate-and-fire neuron. Each tick runs one
// timestep: leak (1 cycle), accumulate the weights of active synapses one per
// cycle (N_IN cycles), then a fire decision (1 cycle). While the refractory
// counter is nonzero a tick instead runs a single REFR cycle that holds the
// potential at 0.
// Ports:
//   clk        in  1     sole clock, rising edge
//   reset      in  1     synchronous, active-low reset
//   tick       in  1     one-cycle timestep strobe
//   inputs     in  N_IN  presynaptic spikes, sampled with tick
//   learn_en   in  1     enables learn pulses
//   w_addr     out 3     synapse weight index (0 outside ACCUM)
//   w_data     in  W     weight at w_addr, combinational same-cycle
//   spike_out  out 1     one-cycle fire pulse
//   learn      out 1     one-cycle STDP update strobe
//   pre_mask   out N_IN  inputs latched at the current tick
//   potential  out W     membrane potential register
//   busy       out 1     high outside IDLE
//   done       out 1     one-cycle end-of-timestep pulse
//   overrun    out 1     sticky: tick arrived while busy
// -----------------------------------------------------------------------------
module neuron_sequencer
    import neuron_pkg::*;
#(
    parameter int N_IN       = N_IN_DEF,
    parameter int W          = W_DEF,
    parameter int THRESH     = THRESH_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
    parameter int REFRAC     = REFRAC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic [N_IN-1:0] inputs,
    input  logic            learn_en,
    output logic [2:0]      w_addr,
    input  logic [W-1:0]    w_data,
    output logic            spike_out,
    output logic            learn,
    output logic [N_IN-1:0] pre_mask,
    output logic [W-1:0]    potential,
    output logic            busy,
    output logic            done,
    output logic            overrun
);

    localparam int              RW       = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
    localparam logic [RW-1:0]   REFRAC_V = RW'(REFRAC);
    localparam logic [W-1:0]    THRESH_V = W'(THRESH);
    localparam logic [2:0]      LAST_IDX = 3'(N_IN - 1);

    state_t         state;
    logic [2:0]     idx;          // synapse currently being accumulated
    logic [RW-1:0]  refrac_cnt;   // remaining refractory ticks
    logic [W-1:0]   leaked;
    logic [W-1:0]   acc_sum;      // potential + w_data, saturated
    logic [W:0]     sum_ext;
    logic           fire;

    leak_shift #(
        .W          (W),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_leak (
        .v        (potential),
        .v_leaked (leaked)
    );

    // Saturating add: the extra carry bit flags overflow, which clamps to all ones.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        sum_ext = '0;
        acc_sum = '0;
        sum_ext = {1'b0, potential} + {1'b0, w_data};
        acc_sum = sum_ext[W] ? '1 : sum_ext[W-1:0];
    end

    // Decision outputs are decoded from state so each is high for exactly
    // the one FIRE or REFR cycle.
    assign fire      = (state == FIRE) && (potential >= THRESH_V);
    assign spike_out = fire;
    assign learn     = fire && learn_en;
    assign done      = (state == FIRE) || (state == REFR);
    assign busy      = (state != IDLE);
    assign w_addr    = (state == ACCUM) ? idx : 3'd0;

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every
        // register updates from the values present before the edge.
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            refrac_cnt <= '0;
            potential  <= '0;
            pre_mask   <= '0;
            overrun    <= 1'b0;
        end else begin
            // A tick outside IDLE is dropped; remember that it happened.
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        pre_mask <= inputs;
                        idx      <= '0;
                        state    <= (refrac_cnt != '0) ? REFR : LEAK;
                    end
                end
                LEAK: begin
                    potential <= leaked;
                    state     <= ACCUM;
                end
                ACCUM: begin
                    if (pre_mask[idx]) begin
                        potential <= acc_sum;
                    end
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= FIRE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                FIRE: begin
                    if (fire) begin
                        potential  <= '0;
                        refrac_cnt <= REFRAC_V;
                    end
                    state <= IDLE;
                end
                REFR: begin
                    refrac_cnt <= refrac_cnt - RW'(1);
                    potential  <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neuron_sequencer
// Directed bench for neuron_sequencer. On every tick the stimulus computes the
// whole expected timestep (per-cycle potential, w_addr, done/spike/learn) from
// the neuron's rules with plain integer arithmetic and queues it; one compare
// process checks the DUT against the queue head, or against the idle values,
// on every falling edge. Literal checks after each scenario pin the model.
// -----------------------------------------------------------------------------
module tb_neuron_sequencer;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       spike;
        logic       learn;
        logic [2:0] w_addr;
        logic [7:0] potential;
        logic [7:0] pre_mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [7:0] inputs;
    logic       learn_en;
    logic [2:0] w_addr;
    logic [7:0] w_data;
    logic       spike_out;
    logic       learn;
    logic [7:0] pre_mask;
    logic [7:0] potential;
    logic       busy;
    logic       done;
    logic       overrun;

    logic [7:0] wmem [8];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state between timesteps.
    exp_t       q[$];
    int         model_v       = 0;
    logic [7:0] model_mask    = '0;
    int         model_refrac  = 0;
    logic       model_overrun = 1'b0;
    bit         cmp_en        = 1'b0;

    // Event monitors for literal checks.
    int         spike_cnt = 0;
    int         learn_cnt = 0;
    int         done_cnt  = 0;
    logic [7:0] last_done_pot = '0;

    always #5 clk = ~clk;

    assign w_data = wmem[w_addr];

    neuron_sequencer #(
        .N_IN       (8),
        .W          (8),
        .THRESH     (128),
        .LEAK_SHIFT (2),
        .REFRAC     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .inputs    (inputs),
        .learn_en  (learn_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .spike_out (spike_out),
        .learn     (learn),
        .pre_mask  (pre_mask),
        .potential (potential),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic b, input logic d, input logic s, input logic l,
                                input logic [2:0] a, input logic [7:0] p, input logic [7:0] m);
        exp_t e;
        e.busy = b; e.done = d; e.spike = s; e.learn = l;
        e.w_addr = a; e.potential = p; e.pre_mask = m;
        return e;
    endfunction

    // Per-cycle compare against the model, plus event monitors.
    always @(negedge clk) begin
        if (cmp_en) begin
            exp_t a;
            exp_t e;
            a = mk(busy, done, spike_out, learn, w_addr, potential, pre_mask);
            if (q.size() > 0) e = q.pop_front();
            else              e = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'(model_v), model_mask);
            check("cycle_outputs", 32'(a), 32'(e));
            check("overrun_flag", 32'(overrun), 32'(model_overrun));
            if (spike_out === 1'b1) spike_cnt++;
            if (learn === 1'b1)     learn_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                last_done_pot = potential;
            end
        end
    end

    // Issue one tick (called at posedge+1 while idle) and queue the expected
    // timestep. Inputs are scrambled right after the tick edge.
    task automatic start_tick(input logic [7:0] mask);
        int  pv;
        bit  fired;
        tick   = 1'b1;
        inputs = mask;
        @(posedge clk); #1;
        tick   = 1'b0;
        inputs = ~mask;
        if (model_refrac > 0) begin
            q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'(model_v), mask));
            model_refrac--;
            model_v = 0;
        end else begin
            pv = model_v;
            q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'(pv), mask));
            pv = pv - pv / 4;
            for (int i = 0; i < 8; i++) begin
                q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'(i), 8'(pv), mask));
                if (mask[i]) pv = (pv + int'(wmem[i]) > 255) ? 255 : pv + int'(wmem[i]);
            end
            fired = (pv >= 128);
            q.push_back(mk(1'b1, 1'b1, fired, fired && learn_en, 3'd0, 8'(pv), mask));
            model_v = fired ? 0 : pv;
            if (fired) model_refrac = 2;
        end
        model_mask = mask;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle_timeout", 32'(ok), 32'd1);
        q.delete();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        q.delete();
        model_v = 0; model_mask = '0; model_refrac = 0; model_overrun = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic set_weights(input logic [7:0] w);
        for (int i = 0; i < 8; i++) wmem[i] = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        tick     = 1'b0;
        inputs   = '0;
        learn_en = 1'b1;
        set_weights(8'd20);
        @(posedge clk); #1;
        cmp_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        check("reset_outputs",
              32'({busy, done, spike_out, learn, w_addr, potential, pre_mask, overrun}), 32'd0);

        // All weights 20, all inputs: 160 -> spike, learn follows learn_en.
        start_tick(8'hFF);
        wait_idle();
        check("full_spike_cnt", spike_cnt, 1);
        check("full_learn_cnt", learn_cnt, 1);
        check("full_fire_pot", 32'(last_done_pot), 32'd160);
        check("full_pot_after", 32'(potential), 32'd0);

        // Two refractory ticks: done only, potential 0; third accumulates.
        start_tick(8'hFF);
        wait_idle();
        start_tick(8'hFF);
        wait_idle();
        check("refr_spike_cnt", spike_cnt, 1);
        check("refr_done_cnt", done_cnt, 3);
        check("refr_pot", 32'(potential), 32'd0);
        start_tick(8'h03);
        wait_idle();
        check("post_refr_pot", 32'(potential), 32'd40);
        check("post_refr_spike_cnt", spike_cnt, 1);

        // 0x0F: 80 no spike; then leak to 60, +80 = 140 -> spike, no learn.
        pulse_reset();
        learn_en = 1'b0;
        start_tick(8'h0F);
        wait_idle();
        check("half_tick1_pot", 32'(potential), 32'd80);
        check("half_tick1_spike_cnt", spike_cnt, 1);
        start_tick(8'h0F);
        wait_idle();
        check("half_tick2_fire_pot", 32'(last_done_pot), 32'd140);
        check("half_tick2_spike_cnt", spike_cnt, 2);
        check("half_tick2_learn_cnt", learn_cnt, 1);
        check("half_tick2_pot", 32'(potential), 32'd0);

        // Weights 200: saturates at 255, then spikes.
        pulse_reset();
        learn_en = 1'b1;
        set_weights(8'd200);
        start_tick(8'hFF);
        wait_idle();
        check("sat_fire_pot", 32'(last_done_pot), 32'd255);
        check("sat_spike_cnt", spike_cnt, 3);
        check("sat_learn_cnt", learn_cnt, 2);

        // Tick during cycle 4 of a timestep is ignored and sets sticky overrun.
        pulse_reset();
        set_weights(8'd20);
        start_tick(8'h01);
        repeat (3) @(posedge clk);
        #1;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        model_overrun = 1'b1;
        wait_idle();
        check("ovr_pot", 32'(potential), 32'd20);
        check("ovr_flag", 32'(overrun), 32'd1);
        start_tick(8'h01);
        wait_idle();
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_tick2_pot", 32'(potential), 32'd35);

        // Reset sampled during the fifth ACCUM cycle forces IDLE with zeros.
        start_tick(8'hFF);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        q.delete();
        model_v = 0; model_mask = '0; model_refrac = 0; model_overrun = 1'b0;
        check("midreset_outputs",
              32'({busy, done, spike_out, learn, w_addr, potential, pre_mask, overrun}), 32'd0);
        start_tick(8'h01);
        wait_idle();
        check("midreset_after_pot", 32'(potential), 32'd20);

        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 SHALL provide parameters, one per line:
- N_IN, 8, number of synaptic inputs.
- W, 8, weight and potential width.
- THRESH, 128, firing threshold.
- LEAK_SHIFT, 2, leak is v>>LEAK_SHIFT per tick.
- REFRAC, 2, refractory length in ticks.
REQ-002 SHALL provide ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock; rising edge.
- reset, in, 1, synchronous, active-low reset.
- tick, in, 1, one-cycle timestep strobe.
- inputs, in, N_IN, presynaptic spikes, sampled with tick.
- learn_en, in, 1, enables learn pulses.
- w_addr, out, 3, synapse weight index.
- w_data, in, W, weight at w_addr; combinational, same-cycle.
- spike_out, out, 1, one-cycle fire pulse.
- learn, out, 1, one-cycle STDP update strobe.
- pre_mask, out, N_IN, latched inputs of the current tick.
- potential, out, W, membrane potential register.
- busy, out, 1, high outside IDLE.
- done, out, 1, one-cycle end-of-timestep pulse.
- overrun, out, 1, sticky flag: tick arrived while busy.

Function
REQ-003 SHALL implement states IDLE, LEAK, ACCUM, FIRE, REFR.
REQ-004 IDLE: tick=1 at edge E0 SHALL latch inputs into pre_mask and go to REFR if the refractory counter is nonzero, else to LEAK.
REQ-005 LEAK (cycle 1) SHALL set potential = v - (v>>LEAK_SHIFT), then go to ACCUM.
REQ-006 ACCUM (cycles 2..9) SHALL drive w_addr = k-2 in cycle k; if pre_mask[w_addr]=1 it SHALL add w_data to potential, saturating at 2^W-1; after index 7 it SHALL go to FIRE.
REQ-007 FIRE (cycle 10): if potential >= THRESH, it SHALL set spike_out=1, set potential to 0, load the refractory counter with REFRAC, and set learn = learn_en; otherwise it SHALL leave potential unchanged.
REQ-008 FIRE SHALL assert done for that cycle and return to IDLE; spike_out, learn and done SHALL each be high for exactly one cycle.
REQ-009 REFR (one cycle) SHALL decrement the refractory counter, hold potential at 0, assert done with spike_out=0, and return to IDLE.
REQ-010 A tick while busy SHALL be ignored and SHALL set overrun, which only reset clears.
REQ-011 w_addr SHALL be 0 outside ACCUM.
REQ-012 busy SHALL equal (state != IDLE).
REQ-013 Changes to inputs after E0 SHALL NOT affect the current timestep.

Reset
REQ-014 reset=0 at a clock edge SHALL force IDLE from any state, including mid-ACCUM.
REQ-015 Reset SHALL clear potential, pre_mask, the refractory counter, overrun, spike_out, learn, done and busy to 0.

Structure
REQ-016 A shared package neuron_pkg SHALL hold the state enum and the defaults for W, N_IN, THRESH, LEAK_SHIFT and REFRAC.
REQ-017 Leak arithmetic SHALL be one combinational sub-module, leak_shift.
REQ-018 The accumulator SHALL be the only datapath register; no multipliers are allowed.

Verification (THRESH=128, LEAK_SHIFT=2, REFRAC=2)
REQ-019 All weights 20, inputs=8'hFF, v=0, tick -> spike_out=1 and done=1 at cycle 10; potential=0; learn=learn_en.
REQ-020 All weights 20, inputs=8'h0F -> tick 1 gives potential 80 with no spike; tick 2 gives leak to 60, then 140, then spike and potential 0.
REQ-021 All weights 200, inputs=8'hFF -> potential saturates at 255 during ACCUM, then spikes.
REQ-022 After a spike, the next two ticks -> done only, no spike, potential 0, w_addr stays 0; the third tick accumulates normally.
REQ-023 Tick at cycle 4 of a timestep -> ignored, overrun=1 until reset.
REQ-024 reset=0 at cycle 5 of ACCUM -> next cycle is IDLE with all outputs 0; a following tick with inputs=8'h01 and weight 20 gives potential 20.
